lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receive-side partner to the 64-bit XNOR LFSR pattern generator.
- Takes the generator's serial output bit (the feedback bit entering position 63 each step) and regenerates the same sequence locally.
- Acquires lock, then counts bit errors. Status drives MCPNR_LIGHTS; CLR_ERR comes from MCPNR_SWITCHES, for on-world link and timing tests.

Parameters:
- LOCK_COUNT, 16: consecutive matching bits required in CHECK before entering LOCKED (1..255).
- LOSS_LIMIT, 8: consecutive mismatches in LOCKED that force return to SEARCH (1..255). Used only with the optional feature.
- ERR_W, 16: width of the saturating error counter.

Ports:
- CLK  input  1  clock
- RST  input  1  reset, synchronous, active-high
- DIN  input  1  received sequence bit
- DIN_VALID  input  1  DIN is sampled only on cycles where this is high; otherwise all state holds
- CLR_ERR  input  1  synchronous clear of ERR_COUNT
- LOCKED  output  1  high while in LOCKED state
- STATE  output  2  0 = SEARCH, 1 = CHECK, 2 = LOCKED
- ERR_PULSE  output  1  one-cycle pulse per counted error
- ERR_COUNT  output  ERR_W  saturating count of errors seen in LOCKED

Behaviour:
- Reset (RST high at a posedge CLK):
  - Values: H = 64'd0, fill = 0, run = 0, miss = 0, STATE = SEARCH, LOCKED = 0, ERR_PULSE = 0, ERR_COUNT = 0.
  - RST has priority over every other input, including mid-lock.
- History register H[63:0] shifts exactly like the generator: H[62:0] <= H[63:1]; H[63] <= load bit.
- Prediction: P = H[0] ^ H[8] ^ H[13] ^ H[31] ^ 1 (combinational from the current H). Match = (DIN == P).
- All outputs are registered and update on the posedge after the valid bit that causes them.
- SEARCH:
  - Load bit = DIN; fill increments (7 bits).
  - After the 64th valid bit, go to CHECK with run = 0.
- CHECK:
  - Load bit = DIN.
  - On match, run++; on mismatch, run = 0 (no error is counted).
  - When run reaches LOCK_COUNT, go to LOCKED and set LOCKED = 1.
- LOCKED:
  - Load bit = P always. This flywheel behaviour means a single flipped bit costs exactly one error.
  - On mismatch: ERR_PULSE = 1 for one cycle, ERR_COUNT increments, and stops at 2^ERR_W - 1.
  - On match: ERR_PULSE = 0 and miss = 0.
- ERR_PULSE is 0 on every cycle without a counted mismatch, including cycles with DIN_VALID low.
- CLR_ERR:
  - CLR_ERR alone sets ERR_COUNT = 0.
  - CLR_ERR together with an error in the same cycle sets ERR_COUNT = 1 and ERR_PULSE = 1.
  - CLR_ERR does not affect the state machine.
- Lock timing from reset with DIN_VALID held high: LOCKED rises on the edge that samples the (64 + LOCK_COUNT)-th valid bit, i.e. the 80th with defaults.
- All-ones history (the XNOR lock-up state) is not special-cased. It predicts 1 forever.

Optional Feature:
- Macro: LFSR_CHECKER_LOSS_EN.
- Defined:
  - In LOCKED, each mismatch increments the miss counter, which is cleared by any match.
  - When miss reaches LOSS_LIMIT: go to SEARCH, LOCKED = 0, fill = 0, run = 0, miss = 0. H is not cleared; it is overwritten by the refill.
  - The mismatch that triggers the loss still pulses ERR_PULSE and counts.
- Not defined:
  - No miss counter is built, and the LOSS_LIMIT parameter is unused.
  - LOCKED is left only by RST.

Test Plan:
- Generator and checker both reset, DIN_VALID = 1, DIN = generator bit 63 -> bits 1–33 = 1, bit 34 = 0; STATE = 1 after 64 bits; LOCKED = 1 on the 80th bit; ERR_COUNT stays 0 over 10,000 bits.
- Once locked, invert one DIN bit -> ERR_PULSE high for exactly one cycle, ERR_COUNT = 1, no further errors over 1,000 bits, LOCKED stays 1.
- DIN_VALID toggled 1/0 every cycle during acquisition -> lock arrives after 80 valid bits (160 cycles); H does not change on invalid cycles.
- With ERR_W = 4, inject 20 single-bit errors spaced 100 bits apart -> ERR_COUNT = 15; CLR_ERR pulsed during an error cycle -> ERR_COUNT = 1.
- With LFSR_CHECKER_LOSS_EN defined, LOSS_LIMIT = 8, feed 8 consecutive inverted bits -> 8 ERR_PULSEs, then STATE = 0 and LOCKED = 0; clean data relocks after 80 further bits. Without the macro -> LOCKED stays 1 and ERR_COUNT = 8.
- Assert RST while LOCKED with ERR_COUNT = 5 -> the next cycle shows STATE = 0, LOCKED = 0, ERR_COUNT = 0, ERR_PULSE = 0.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 64-bit XNOR LFSR generator; acquires lock, then counts bit errors.
// Define LFSR_CHECKER_LOSS_EN to drop lock after LOSS_LIMIT consecutive mismatches.
module lfsr_checker #(
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_LIMIT = 8,
  parameter int ERR_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DIN,
  input  logic             DIN_VALID,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic [1:0]       STATE,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_COUNT
);
  localparam logic [1:0] SEARCH = 2'd0, CHECK = 2'd1, LOCK = 2'd2;
  logic [63:0] h;
  logic [6:0]  fill;
  logic [7:0]  run;
  logic        p, match, err, loss;
  if (LOCK_COUNT < 1 || LOCK_COUNT > 255 || LOSS_LIMIT < 1 || LOSS_LIMIT > 255) begin : g_bad_param
    $error("lfsr_checker: LOCK_COUNT and LOSS_LIMIT must be 1..255");
  end
  assign p     = ~(h[0] ^ h[8] ^ h[13] ^ h[31]);
  assign match = DIN == p;
  assign err   = DIN_VALID && STATE == LOCK && !match;
`ifdef LFSR_CHECKER_LOSS_EN
  logic [7:0] miss;
  assign loss = err && miss == 8'(LOSS_LIMIT - 1);
  always_ff @(posedge CLK)
    if (RST) miss <= '0;
    else if (DIN_VALID && STATE == LOCK) miss <= (match || loss) ? 8'd0 : miss + 8'd1;
`else
  assign loss = 1'b0;
`endif
  always_ff @(posedge CLK)
    if (RST) begin
      h         <= '0;
      fill      <= '0;
      run       <= '0;
      STATE     <= SEARCH;
      LOCKED    <= 1'b0;
      ERR_PULSE <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      ERR_PULSE <= err;
      if (CLR_ERR) ERR_COUNT <= ERR_W'(err);
      else if (err && !(&ERR_COUNT)) ERR_COUNT <= ERR_COUNT + ERR_W'(1);
      if (DIN_VALID) begin
        // once locked the history flywheels on its own prediction so a flipped bit costs one error
        h <= {STATE == LOCK ? p : DIN, h[63:1]};
        if (STATE == SEARCH) begin
          fill <= fill + 7'd1;
          if (fill == 7'd63) begin
            STATE <= CHECK;
            run   <= '0;
          end
        end else if (STATE == CHECK) begin
          run <= match ? run + 8'd1 : 8'd0;
          if (match && run == 8'(LOCK_COUNT - 1)) begin
            STATE  <= LOCK;
            LOCKED <= 1'b1;
          end
        end else if (loss) begin
          STATE  <= SEARCH;
          LOCKED <= 1'b0;
          fill   <= '0;
          run    <= '0;
        end
      end
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench driving a reference XNOR generator into two checkers (ERR_W 16 and 4).
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst, din, din_valid, clr_err;
  logic        locked, locked4, err_pulse, err_pulse4;
  logic [1:0]  state, state4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [63:0] g;
  int          tests = 0, fails = 0;
  typedef struct {string tag; int sel; int val;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  lfsr_checker u_dut (
    .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .CLR_ERR(clr_err),
    .LOCKED(locked), .STATE(state), .ERR_PULSE(err_pulse), .ERR_COUNT(err_count)
  );
  lfsr_checker #(.ERR_W(4)) u_dut4 (
    .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .CLR_ERR(clr_err),
    .LOCKED(locked4), .STATE(state4), .ERR_PULSE(err_pulse4), .ERR_COUNT(err_count4)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] probe(input int sel);
    return sel == 0 ? 32'(state) : sel == 1 ? 32'(locked) : sel == 2 ? 32'(err_pulse) :
           sel == 3 ? 32'(err_count) : sel == 4 ? 32'(err_count4) : sel == 5 ? 32'(state4) :
           sel == 6 ? 32'(locked4) : 32'(err_pulse4);
  endfunction
  task automatic want(input string tag, input int sel, input int val);
    sb.push_back('{tag, sel, val});
  endtask
  task automatic cyc(input logic v, input logic flip, input logic clr, input logic r);
    logic gb;
    @(negedge clk);
    rst = r;
    din_valid = v;
    clr_err = clr;
    if (v && !r) begin
      gb = ~(g[0] ^ g[8] ^ g[13] ^ g[31]);
      din = gb ^ flip;
      g = {gb, g[63:1]};
    end else din = 1'($urandom);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, probe(e.sel), e.val);
    end
  endtask
  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_err = 1'b0; g = '0;
    cyc(0, 0, 0, 1);
    want("rst_state", 0, 0); want("rst_locked", 1, 0); want("rst_pulse", 2, 0); want("rst_count", 3, 0);
    cyc(0, 0, 0, 1);
    g = '0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 63) want("search63", 0, 0);
      if (i == 64) want("check64", 0, 1);
      if (i == 79) want("nolock79", 1, 0);
      if (i == 80) begin want("lock80", 1, 1); want("lock80_state", 0, 2); want("lock80_w4", 6, 1); end
      cyc(1, 0, 0, 0);
    end
    for (int i = 0; i < 10000; i++) begin
      want("clean_pulse", 2, 0);
      if (i == 9999) begin want("clean_count", 3, 0); want("clean_locked", 1, 1); end
      cyc(1, 0, 0, 0);
    end
    want("flip_pulse", 2, 1); want("flip_count", 3, 1); want("flip_locked", 1, 1);
    cyc(1, 1, 0, 0);
    want("flip_pulse_end", 2, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 999; i++) begin
      if (i == 998) begin want("flip_after_count", 3, 1); want("flip_after_locked", 1, 1); end
      cyc(1, 0, 0, 0);
    end
    for (int k = 0; k < 20; k++) begin
      want("sat_pulse", 7, 1);
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 99; i++) cyc(1, 0, 0, 0);
    end
    want("sat_count16", 3, 21); want("sat_count4", 4, 15);
    cyc(1, 0, 0, 0);
    want("clr_err_count", 3, 1); want("clr_err_count4", 4, 1); want("clr_err_pulse", 2, 1);
    cyc(1, 1, 1, 0);
    want("clr_only_count", 3, 0); want("clr_only_count4", 4, 0); want("clr_only_pulse", 2, 0);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      want("loss_pulse", 2, 1);
      if (i == 7) begin
        want("loss_count", 3, 8);
`ifdef LFSR_CHECKER_LOSS_EN
        want("loss_state", 0, 0); want("loss_locked", 1, 0);
`else
        want("loss_state", 0, 2); want("loss_locked", 1, 1);
`endif
      end
      cyc(1, 1, 0, 0);
    end
    for (int i = 1; i <= 80; i++) begin
`ifdef LFSR_CHECKER_LOSS_EN
      if (i == 79) want("relock79", 1, 0);
`endif
      if (i == 80) begin want("relock80", 1, 1); want("relock80_count", 3, 8); end
      cyc(1, 0, 0, 0);
    end
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 0, 0, 0);
    end
    want("pre_rst_count", 3, 5); want("pre_rst_locked", 1, 1);
    cyc(1, 0, 0, 0);
    want("mid_rst_state", 0, 0); want("mid_rst_locked", 1, 0);
    want("mid_rst_count", 3, 0); want("mid_rst_pulse", 2, 0);
    cyc(1, 1, 0, 1);
    g = '0;
    for (int i = 1; i <= 80; i++) begin
      if (i == 64) want("tog_check", 0, 1);
      if (i == 79) want("tog_nolock", 1, 0);
      if (i == 80) begin want("tog_lock", 1, 1); want("tog_lock4", 6, 1); end
      cyc(1, 0, 0, 0);
      if (i < 80) begin
        if (i == 64) want("tog_hold", 0, 1);
        cyc(0, 0, 0, 0);
      end
    end
    for (int i = 0; i < 20; i++) begin
      want("invalid_pulse", 2, 0); want("invalid_count", 3, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
